// File: rtl/sd_pkg.sv
// ----------------------------------------------------------------------------
// sd_pkg
// Shared constants and FSM encoding for the SD card clock controller.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package sd_pkg;

  // Width of the half-period divide value
  localparam int DIV_W    = 8;
  // Divide value after reset: 50 MHz / (2 * 63) ~= 397 kHz identification rate
  localparam int INIT_DIV = 62;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_STOPPING = 2'd2
  } sd_state_e;

endpackage

`default_nettype wire

// File: rtl/sd_clk_div.sv
// ----------------------------------------------------------------------------
// sd_clk_div
// Half-period counter, registered SD clock toggle and edge tick generation.
// Ticks are asserted in the cycle whose closing clk edge changes o_sd_clk.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module sd_clk_div #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  input  logic [DIV_W-1:0] i_div,
  output logic             o_sd_clk,
  output logic             o_rise_tick,
  output logic             o_fall_tick
);

  logic [DIV_W-1:0] r_cnt;
  logic             r_sd_clk;
  logic             w_toggle;

  assign w_toggle    = i_en && (r_cnt == i_div);
  assign o_rise_tick = w_toggle && !r_sd_clk;
  assign o_fall_tick = w_toggle &&  r_sd_clk;
  assign o_sd_clk    = r_sd_clk;

  // Count the half period; toggle the clock and restart when it expires
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_sd_clk <= 1'b0;
    end else if (!i_en) begin
      r_cnt    <= '0;
      r_sd_clk <= 1'b0;
    end else if (w_toggle) begin
      r_cnt    <= '0;
      r_sd_clk <= !r_sd_clk;
    end else begin
      r_cnt    <= r_cnt + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/sd_clk_ctrl.sv
// ----------------------------------------------------------------------------
// sd_clk_ctrl
// SD card clock controller: run/stop FSM that only stops on a falling edge,
// plus a req/ack handshake that swaps the divide value glitch-free.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module sd_clk_ctrl #(
  parameter int DIV_W    = sd_pkg::DIV_W,
  parameter int INIT_DIV = sd_pkg::INIT_DIV
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_run,
  input  logic             i_cfg_req,
  input  logic [DIV_W-1:0] i_cfg_div,
  output logic             o_cfg_ack,
  output logic             o_sd_clk,
  output logic             o_rise_tick,
  output logic             o_fall_tick,
  output logic             o_running
);

  import sd_pkg::*;

  sd_state_e        r_state;
  sd_state_e        w_state_nxt;
  logic [DIV_W-1:0] r_div;
  logic [DIV_W-1:0] r_pend_div;
  logic             r_pend_vld;
  logic             r_armed;
  logic             w_en;
  logic             w_fall;
  logic             w_load;
  logic             w_capture;

  assign w_en      = (r_state != ST_IDLE);
  assign o_running = w_en;

  // A pending value is applied at once when idle, else only on a falling
  // edge, where the counter restarts so no half period is cut short.
  assign w_load    = r_pend_vld && ((r_state == ST_IDLE) || w_fall);
  assign o_cfg_ack = w_load;

  // Only a fresh request (low seen since the last ack) is captured
  assign w_capture = i_cfg_req && !r_pend_vld && r_armed;

  sd_clk_div #(
    .DIV_W (DIV_W)
  ) u_div (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_en        (w_en),
    .i_div       (r_div),
    .o_sd_clk    (o_sd_clk),
    .o_rise_tick (o_rise_tick),
    .o_fall_tick (w_fall)
  );

  assign o_fall_tick = w_fall;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state: stopping waits for the falling edge so the clock ends low
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (i_run) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (!i_run) w_state_nxt = ST_STOPPING;
      end
      ST_STOPPING: begin
        if (i_run)       w_state_nxt = ST_RUN;
        else if (w_fall) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Config handshake: capture pending value, load active divide, re-arm
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div      <= DIV_W'(INIT_DIV);
      r_pend_div <= '0;
      r_pend_vld <= 1'b0;
      r_armed    <= 1'b1;
    end else begin
      if (w_load) begin
        r_div      <= r_pend_div;
        r_pend_vld <= 1'b0;
      end else if (w_capture) begin
        r_pend_div <= i_cfg_div;
        r_pend_vld <= 1'b1;
      end
      if (!i_cfg_req) begin
        r_armed <= 1'b1;
      end else if (w_load) begin
        r_armed <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire
